// File: rtl/ps2_controller_pkg.sv
// Shared definitions for the PS/2 controller: state encoding, default
// timing constants (50 MHz clock) and the odd-parity helper.
package ps2_controller_pkg;

    // Default timing in CLOCK_50 cycles
    localparam int unsigned DEF_CYCLES_101US = 5050;
    localparam int unsigned DEF_CYCLES_15MS  = 750000;
    localparam int unsigned DEF_CYCLES_2MS   = 100000;

    // Legacy state encodings, kept so older code decoding the raw value still agrees
    localparam logic [2:0] ST_IDLE        = 3'd0;
    localparam logic [2:0] ST_RX          = 3'd1;
    localparam logic [2:0] ST_TX_INHIBIT  = 3'd2;
    localparam logic [2:0] ST_TX_START    = 3'd3;
    localparam logic [2:0] ST_TX_BITS     = 3'd4;
    localparam logic [2:0] ST_TX_WAIT_ACK = 3'd5;
    localparam logic [2:0] ST_DONE        = 3'd6;

    typedef enum logic [2:0] {
        IDLE        = ST_IDLE,
        RX          = ST_RX,
        TX_INHIBIT  = ST_TX_INHIBIT,
        TX_START    = ST_TX_START,
        TX_BITS     = ST_TX_BITS,
        TX_WAIT_ACK = ST_TX_WAIT_ACK,
        DONE        = ST_DONE
    } ps2_state_e;

    // Parity bit that makes data plus parity contain an odd number of ones
    function automatic logic odd_parity(input logic [7:0] data);
        return ~^data;
    endfunction

endpackage

// File: rtl/ps2_command_out.sv
// Host-to-device command path: clock inhibit, start bit, data/parity/stop
// shifting on device falling edges, acknowledge detection and timeouts.
// Result flags are held in DONE until send_command_i drops.
module ps2_command_out
    import ps2_controller_pkg::*;
#(
    parameter int unsigned CYCLES_101US = DEF_CYCLES_101US,
    parameter int unsigned CYCLES_15MS  = DEF_CYCLES_15MS,
    parameter int unsigned CYCLES_2MS   = DEF_CYCLES_2MS
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    input  logic [7:0] command_i,
    input  logic       send_command_i,
    input  logic       ps2_clk_fall_i,
    input  logic       ps2_dat_i,
    output logic       busy_o,
    output logic       clk_drive_low_o,
    output logic       dat_drive_low_o,
    output logic       command_was_sent_o,
    output logic       timed_out_o
);

    localparam int unsigned TMAX_A = (CYCLES_15MS > CYCLES_2MS) ? CYCLES_15MS : CYCLES_2MS;
    localparam int unsigned TMAX   = (TMAX_A > CYCLES_101US) ? TMAX_A : CYCLES_101US;
    localparam int unsigned TW     = $clog2(TMAX + 1);

    ps2_state_e      state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [3:0]      bit_q, bit_d;
    logic [8:0]      frame_q, frame_d;
    logic            sent_q, sent_d;
    logic            err_q, err_d;
    logic            clk_low_q, clk_low_d;
    logic            dat_low_q, dat_low_d;

    // Next-state logic; the timer restarts on every state entry
    always_comb begin
        state_d = state_q;
        timer_d = timer_q + 1'b1;
        bit_d   = bit_q;
        frame_d = frame_q;
        sent_d  = sent_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                timer_d = '0;
                if (start_i) begin
                    frame_d = {odd_parity(command_i), command_i};
                    bit_d   = '0;
                    state_d = TX_INHIBIT;
                end
            end
            TX_INHIBIT: begin
                if (timer_q == TW'(CYCLES_101US - 1)) begin
                    state_d = TX_START;
                    timer_d = '0;
                end
            end
            TX_START: begin
                if (ps2_clk_fall_i) begin
                    state_d = TX_BITS;
                    timer_d = '0;
                    bit_d   = '0;
                end else if (timer_q == TW'(CYCLES_15MS - 1)) begin
                    state_d = DONE;
                    err_d   = 1'b1;
                end
            end
            TX_BITS: begin
                // Parity is on the line after the 9th edge; the next edge releases for stop
                if (ps2_clk_fall_i && bit_q == 4'd8) begin
                    state_d = TX_WAIT_ACK;
                    timer_d = '0;
                end else if (timer_q == TW'(CYCLES_2MS - 1)) begin
                    state_d = DONE;
                    err_d   = 1'b1;
                end else if (ps2_clk_fall_i) begin
                    bit_d = bit_q + 4'd1;
                end
            end
            TX_WAIT_ACK: begin
                if (ps2_clk_fall_i && !ps2_dat_i) begin
                    state_d = DONE;
                    sent_d  = 1'b1;
                end else if (timer_q == TW'(CYCLES_2MS - 1)) begin
                    state_d = DONE;
                    err_d   = 1'b1;
                end
            end
            DONE: begin
                timer_d = '0;
                if (!send_command_i) begin
                    state_d = IDLE;
                    sent_d  = 1'b0;
                    err_d   = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                timer_d = '0;
            end
        endcase
        // Line drivers are registered so decode glitches never reach the bus
        clk_low_d = (state_d == TX_INHIBIT);
        dat_low_d = (state_d == TX_START) || ((state_d == TX_BITS) && !frame_d[bit_d]);
    end

    // State and datapath registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            bit_q     <= '0;
            frame_q   <= '0;
            sent_q    <= 1'b0;
            err_q     <= 1'b0;
            clk_low_q <= 1'b0;
            dat_low_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            bit_q     <= bit_d;
            frame_q   <= frame_d;
            sent_q    <= sent_d;
            err_q     <= err_d;
            clk_low_q <= clk_low_d;
            dat_low_q <= dat_low_d;
        end
    end

    assign busy_o             = (state_q != IDLE);
    assign clk_drive_low_o    = clk_low_q;
    assign dat_drive_low_o    = dat_low_q;
    assign command_was_sent_o = sent_q;
    assign timed_out_o        = err_q;

endmodule

// File: rtl/ps2_controller.sv
// PS/2 host controller: synchronizes the open-drain lines, receives device
// frames and hands command transmission to ps2_command_out.
module ps2_controller
    import ps2_controller_pkg::*;
#(
    parameter int unsigned CYCLES_101US = DEF_CYCLES_101US,
    parameter int unsigned CYCLES_15MS  = DEF_CYCLES_15MS,
    parameter int unsigned CYCLES_2MS   = DEF_CYCLES_2MS
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic [7:0] the_command,
    input  logic       send_command,
    inout  wire        PS2_CLK,
    inout  wire        PS2_DAT,
    output logic       command_was_sent,
    output logic       error_communication_timed_out,
    output logic [7:0] received_data,
    output logic       received_data_en
);

    logic [1:0] clk_sync_q;
    logic [1:0] dat_sync_q;
    logic       clk_prev_q;
    logic       clk_fall;
    logic       dat_s;

    // Receive side uses only IDLE and RX; TX states live in ps2_command_out
    ps2_state_e state_q, state_d;
    logic [3:0] rx_bit_q, rx_bit_d;
    logic [7:0] rx_shift_q, rx_shift_d;
    logic       rx_par_q, rx_par_d;
    logic [7:0] data_q, data_d;
    logic       en_q, en_d;
    logic       tx_start;

    logic       tx_busy;
    logic       tx_clk_low;
    logic       tx_dat_low;
    logic       tx_sent;
    logic       tx_err;

    // Two-flop synchronizers plus one extra stage for falling-edge detection
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            clk_sync_q <= '0;
            dat_sync_q <= '0;
            clk_prev_q <= 1'b0;
        end else begin
            clk_sync_q <= {clk_sync_q[0], PS2_CLK};
            dat_sync_q <= {dat_sync_q[0], PS2_DAT};
            clk_prev_q <= clk_sync_q[1];
        end
    end

    assign clk_fall = clk_prev_q & ~clk_sync_q[1];
    assign dat_s    = dat_sync_q[1];

    // Receive FSM and arbitration; a start bit beats a simultaneous command request
    always_comb begin
        state_d    = state_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_par_d   = rx_par_q;
        data_d     = data_q;
        en_d       = 1'b0;
        tx_start   = 1'b0;
        case (state_q)
            IDLE: begin
                if (!tx_busy) begin
                    if (clk_fall && !dat_s) begin
                        state_d  = RX;
                        rx_bit_d = '0;
                    end else if (send_command) begin
                        tx_start = 1'b1;
                    end
                end
            end
            RX: begin
                if (clk_fall) begin
                    if (rx_bit_q < 4'd8) begin
                        rx_shift_d = {dat_s, rx_shift_q[7:1]};
                        rx_bit_d   = rx_bit_q + 4'd1;
                    end else if (rx_bit_q == 4'd8) begin
                        rx_par_d = dat_s;
                        rx_bit_d = rx_bit_q + 4'd1;
                    end else begin
                        state_d = IDLE;
                        if (dat_s && (odd_parity(rx_shift_q) == rx_par_q)) begin
                            data_d = rx_shift_q;
                            en_d   = 1'b1;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Receive registers
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q    <= IDLE;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_par_q   <= 1'b0;
            data_q     <= '0;
            en_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_par_q   <= rx_par_d;
            data_q     <= data_d;
            en_q       <= en_d;
        end
    end

    ps2_command_out #(
        .CYCLES_101US (CYCLES_101US),
        .CYCLES_15MS  (CYCLES_15MS),
        .CYCLES_2MS   (CYCLES_2MS)
    ) u_command_out (
        .clk_i              (CLOCK_50),
        .rst_i              (reset),
        .start_i            (tx_start),
        .command_i          (the_command),
        .send_command_i     (send_command),
        .ps2_clk_fall_i     (clk_fall),
        .ps2_dat_i          (dat_s),
        .busy_o             (tx_busy),
        .clk_drive_low_o    (tx_clk_low),
        .dat_drive_low_o    (tx_dat_low),
        .command_was_sent_o (tx_sent),
        .timed_out_o        (tx_err)
    );

    // Open-drain: pull low or release, never drive high
    assign PS2_CLK = tx_clk_low ? 1'b0 : 1'bz;
    assign PS2_DAT = tx_dat_low ? 1'b0 : 1'bz;

    assign received_data                 = data_q;
    assign received_data_en              = en_q;
    assign command_was_sent              = tx_sent;
    assign error_communication_timed_out = tx_err;

endmodule

// File: tb/tb_ps2_controller.sv
// Testbench for ps2_controller: device model on the open-drain lines plus a
// per-cycle output model checked against the DUT.
module tb_ps2_controller;

    localparam int INH = 50;
    localparam int T15 = 2000;
    localparam int T2  = 1000;
    localparam int LAT = 3;   // line change to registered reaction

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] cmd = 8'h00;
    logic       send = 1'b0;
    logic       dev_clk_low = 1'b0;
    logic       dev_dat_low = 1'b0;
    wire        ps2_clk;
    wire        ps2_dat;
    logic       sent, err, en;
    logic [7:0] rdata;

    assign ps2_clk = dev_clk_low ? 1'b0 : 1'bz;
    assign ps2_dat = dev_dat_low ? 1'b0 : 1'bz;
    pullup (ps2_clk);
    pullup (ps2_dat);

    ps2_controller #(
        .CYCLES_101US (INH),
        .CYCLES_15MS  (T15),
        .CYCLES_2MS   (T2)
    ) dut (
        .CLOCK_50                      (clk),
        .reset                         (rst),
        .the_command                   (cmd),
        .send_command                  (send),
        .PS2_CLK                       (ps2_clk),
        .PS2_DAT                       (ps2_dat),
        .command_was_sent              (sent),
        .error_communication_timed_out (err),
        .received_data                 (rdata),
        .received_data_en              (en)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Output model: scheduled events set what each output must be
    bit         chk_on = 1'b0;
    logic [7:0] m_data = 8'h00;
    logic [7:0] m_pend = 8'h00;
    logic       m_sent = 1'b0;
    logic       m_err  = 1'b0;
    int m_en_cyc = -1, m_sent_cyc = -1, m_err_cyc = -1, m_clr_cyc = -1, m_rst_cyc = -1;

    always @(negedge clk) begin
        if (chk_on) begin
            if (cyc == m_rst_cyc) begin m_data = 8'h00; m_sent = 1'b0; m_err = 1'b0; end
            if (cyc == m_en_cyc)   m_data = m_pend;
            if (cyc == m_sent_cyc) m_sent = 1'b1;
            if (cyc == m_err_cyc)  m_err  = 1'b1;
            if (cyc == m_clr_cyc)  begin m_sent = 1'b0; m_err = 1'b0; end
            chk("received_data", rdata, m_data);
            chk("received_data_en", en, cyc == m_en_cyc);
            chk("command_was_sent", sent, m_sent);
            chk("timed_out", err, m_err);
        end
    end

    // Monitors feeding literal checks
    int   low_run = 0;
    int   strobes = 0;
    int   err_rise = -1;
    logic err_prev = 1'b0;
    always @(negedge clk) begin
        if (ps2_clk === 1'b0 && !dev_clk_low) low_run++;
        if (en === 1'b1) strobes++;
        if (err === 1'b1 && !err_prev) err_rise = cyc;
        err_prev = err;
    end

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Device-to-host frame; nbits < 11 abandons the frame part-way
    task automatic dev_send(input logic [7:0] d, input logic par, input logic stop, input int nbits);
        logic [10:0] fr;
        fr = {stop, par, d, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            dev_dat_low = !fr[i];
            wait_neg(5);
            dev_clk_low = 1'b1;
            if (i == 10 && stop && ((^{d, par}) == 1'b1)) begin
                m_pend   = d;
                m_en_cyc = cyc + LAT;
            end
            wait_neg(10);
            dev_clk_low = 1'b0;
            wait_neg(5);
        end
        @(negedge clk);
        dev_dat_low = 1'b0;
        wait_neg(10);
    endtask

    // Device side of a host command: clock out 10 bits, optionally acknowledge
    task automatic dev_tx(output logic [9:0] bits, input logic ack);
        int n;
        int ack_cyc;
        n = 0;
        bits = '0;
        while (!(ps2_clk === 1'b1 && ps2_dat === 1'b0) && n < INH + T15) begin
            @(negedge clk);
            n++;
        end
        chk("tx_start_seen", n < INH + T15, 1);
        wait_neg(5);
        for (int i = 0; i < 10; i++) begin
            dev_clk_low = 1'b1;
            wait_neg(10);
            dev_clk_low = 1'b0;
            wait_neg(5);
            bits[i] = ps2_dat;
            wait_neg(5);
        end
        if (ack) begin
            dev_dat_low = 1'b1;
            wait_neg(2);
            dev_clk_low = 1'b1;
            ack_cyc = cyc;
            m_sent_cyc = ack_cyc + LAT;
            if (!send) m_clr_cyc = ack_cyc + LAT + 1;
            wait_neg(10);
            dev_clk_low = 1'b0;
            wait_neg(5);
            dev_dat_low = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        logic [9:0] bits;
        int s0;
        int st;

        // Reset state
        wait_neg(3);
        chk_on = 1'b1;
        chk("reset_clk_line", ps2_clk, 1);
        chk("reset_dat_line", ps2_dat, 1);
        rst = 1'b0;
        wait_neg(5);

        // Single valid frame 0x1C, parity 0
        dev_send(8'h1C, 1'b0, 1'b1, 11);
        chk("rx_1C", rdata, 8'h1C);

        // Back-to-back frames 0xF0 then 0x70
        s0 = strobes;
        dev_send(8'hF0, 1'b1, 1'b1, 11);
        chk("rx_F0", rdata, 8'hF0);
        dev_send(8'h70, 1'b0, 1'b1, 11);
        chk("rx_70", rdata, 8'h70);
        chk("two_strobes", strobes - s0, 2);

        // Bad parity and bad stop bit are both dropped
        s0 = strobes;
        dev_send(8'h1C, 1'b1, 1'b1, 11);
        chk("rx_bad_parity_hold", rdata, 8'h70);
        dev_send(8'h55, 1'b1, 1'b0, 11);
        chk("rx_bad_stop_hold", rdata, 8'h70);
        chk("no_strobe_bad", strobes - s0, 0);

        // Command 0xFF with acknowledge, send_command held
        @(negedge clk);
        cmd = 8'hFF;
        send = 1'b1;
        low_run = 0;
        dev_tx(bits, 1'b1);
        chk("inhibit_len", low_run, 50);
        chk("tx_bits_FF", bits, 10'b11_1111_1111);
        wait_neg(20);
        chk("sent_held", sent, 1);
        send = 1'b0;
        m_clr_cyc = cyc + 1;
        wait_neg(3);

        // Command 0x1C, send_command dropped mid-transfer, command changed after latch
        @(negedge clk);
        cmd = 8'h1C;
        send = 1'b1;
        fork
            dev_tx(bits, 1'b1);
            begin
                wait_neg(INH + 30);
                send = 1'b0;
                cmd = 8'hFF;
            end
        join
        chk("tx_bits_1C", bits, 10'b10_0001_1100);
        wait_neg(5);

        // No device clock: timeout after inhibit plus 15 ms window
        @(negedge clk);
        cmd = 8'hA5;
        send = 1'b1;
        st = cyc;
        m_err_cyc = st + 1 + INH + T15;
        wait_neg(INH + T15 + 10);
        chk("timeout_latency", err_rise - st, 2051);
        chk("timeout_flag", err, 1);
        send = 1'b0;
        m_clr_cyc = cyc + 1;
        wait_neg(3);

        // Reset in the middle of a received frame (after 4 data bits)
        dev_send(8'hAA, 1'b1, 1'b1, 5);
        rst = 1'b1;
        m_rst_cyc = cyc + 1;
        wait_neg(2);
        chk("rst_rx_data", rdata, 0);
        chk("rst_rx_clk_line", ps2_clk, 1);
        chk("rst_rx_dat_line", ps2_dat, 1);
        rst = 1'b0;
        wait_neg(5);
        dev_send(8'h1C, 1'b0, 1'b1, 11);
        chk("rx_after_reset", rdata, 8'h1C);

        // Reset during clock inhibit releases the lines
        @(negedge clk);
        cmd = 8'h12;
        send = 1'b1;
        wait_neg(10);
        chk("inhibit_drives_clk", ps2_clk, 0);
        rst = 1'b1;
        send = 1'b0;
        m_rst_cyc = cyc + 1;
        wait_neg(2);
        chk("rst_tx_clk_line", ps2_clk, 1);
        chk("rst_tx_dat_line", ps2_dat, 1);
        rst = 1'b0;
        wait_neg(5);

        chk_on = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
